receiver: RTL and testbench
===========================

Name: receiver

Overview:
UART receive stage that consumes the serial line produced by the team's UART transmitter. Frame format is 1 start bit (0), 8 data bits LSB first, 1 parity bit and 1 stop bit (1). Parity is even by default, so the parity bit equals the XOR of the data. The block oversamples the line using a clock-enable tick from the shared baud generator. It delivers a byte with ready/clear handshake and parity, framing and overrun status.

Parameters:
OVERSAMPLE, 16, rx_clk_en ticks per bit period; must be even and at least 4.
PARITY_ODD, 0, 0 = even parity expected (matches transmitter); 1 = odd.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, asynchronous to clk, idles high
rx_clk_en  input  1  oversample tick, one clk wide, OVERSAMPLE per bit period
rdy_clr  input  1  consumer acknowledge; clears rdy and status flags
dout  output  8  last received byte
rdy  output  1  dout and flags valid, held until rdy_clr
parity_err  output  1  parity mismatch on the byte in dout
frame_err  output  1  stop bit sampled low on the byte in dout
overrun  output  1  byte completed while previous rdy was still set and not being cleared
rx_busy  output  1  high whenever the state is not IDLE (counterpart to tx_busy)

Behaviour:
- Reset (async): state=IDLE, cnt=0, bit_idx=0, shift=0x00, dout=0x00, rdy=0, parity_err=0, frame_err=0, overrun=0. The synchronizer flops reset to 1 (idle line).
- rx passes through a 2-flop synchronizer, giving rx_s. This adds 2 clk of latency. All decisions below use rx_s.
- Counters and transitions advance only on cycles with rx_clk_en=1. On other cycles all state holds. rdy_clr acts on every clk regardless of rx_clk_en.
- IDLE: on a tick with rx_s=0, go to START with cnt=0.
- START: each tick increments cnt. At the tick where cnt==OVERSAMPLE/2-1 (mid start bit):
  - rx_s=0: go to DATA with cnt=0 and bit_idx=0.
  - rx_s=1: the low was a glitch; return to IDLE with no output change.
- DATA: each tick increments cnt. At cnt==OVERSAMPLE-1:
  - shift = {rx_s, shift[7:1]}, cnt=0, bit_idx increments.
  - After the sample with bit_idx==7, go to PARITY.
- PARITY: at cnt==OVERSAMPLE-1, capture pbit=rx_s, set cnt=0, go to STOP.
- STOP: at cnt==OVERSAMPLE-1, in a single clk edge:
  - dout <= shift, rdy <= 1
  - parity_err <= (^shift ^ pbit) != PARITY_ODD
  - frame_err <= ~rx_s
  - overrun <= rdy & ~rdy_clr
  - state <= IDLE
- Latency: rdy rises on the clk edge after the rx_clk_en cycle that samples mid stop bit.
- rdy_clr:
  - rdy_clr=1 with no completion that cycle: clears rdy, parity_err, frame_err and overrun next edge. dout holds.
  - rdy_clr and frame completion in the same cycle: completion wins. rdy=1, the new flags load, overrun=0.
- Break (rx held low): each frame completes with dout=0x00, frame_err=1, parity_err=0. The block re-enters START on the next tick. No lockup.
- Reset mid-frame aborts immediately. A partial byte is never delivered.
- Bit timing tolerance: sampling is at the centre of each bit, ±OVERSAMPLE/2 ticks.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings: IDLE, START, DATA, PARITY, STOP (3-bit)
  - DATA_BITS=8
  - default OVERSAMPLE=16
- The transmitter's state constants are aligned to this package.
- One sub-module: uart_rx_sync, a 2-flop synchronizer with async active-high reset to 1.
- Counter width is $clog2(OVERSAMPLE).

Test Plan:
1. Clean frame: rx_clk_en every clk, 16 clk per bit. Send 0xA5 with parity bit 0 and stop 1 -> dout=0xA5, rdy=1, parity_err=0, frame_err=0, overrun=0, rx_busy low after stop.
2. Parity error: send 0x01 with parity bit 0 -> dout=0x01, parity_err=1. Then rdy_clr pulse -> rdy=0, parity_err=0, dout still 0x01.
3. Framing and break: send 0x3C with the stop bit low -> frame_err=1. Hold rx low for 3 frame times -> repeated rdy with dout=0x00, frame_err=1, parity_err=0.
4. Glitch and overrun:
   - rx low for 4 ticks then high -> rx_busy pulses, rdy stays 0.
   - Send 0x11 then 0x22 without rdy_clr -> dout=0x22, overrun=1.
   - Repeat with rdy_clr coinciding with the second completion -> overrun=0, rdy=1.
5. Reset mid-frame: assert rst during bit 4 of 0xFF -> all outputs 0 immediately. A following frame 0x5A is received correctly.
6. Loopback: transmitter driven with clk_en at clk/16, receiver with rx_clk_en every clk. Sweep bytes 0x00-0xFF -> every dout matches din, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and frame constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int DATA_BITS          = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/receiver.sv
// rtl/receiver.sv - oversampled UART receiver: 8 data bits, parity, 1 stop, rdy/clear handshake
module receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_clk_en,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rdy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pbit_q, pbit_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 rdy_q, rdy_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    pbit_d       = pbit_q;
    dout_d       = dout_q;
    rdy_d        = rdy_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;

    // Clear is applied first so a completion in the same cycle overrides it.
    if (rdy_clr) begin
      rdy_d        = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end

    if (rx_clk_en) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d     = '0;
            bit_idx_d = '0;
            state_d   = rx_s ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            cnt_d     = '0;
            bit_idx_d = bit_idx_q + BW'(1);
            if (bit_idx_q == IDX_LAST) state_d = PARITY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PARITY: begin
          if (cnt_q == CNT_LAST) begin
            pbit_d  = rx_s;
            cnt_d   = '0;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            dout_d       = shift_q;
            rdy_d        = 1'b1;
            parity_err_d = ((^shift_q) ^ pbit_q) != PARITY_ODD;
            frame_err_d  = ~rx_s;
            overrun_d    = rdy_q & ~rdy_clr;
            cnt_d        = '0;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      pbit_q       <= 1'b0;
      dout_q       <= '0;
      rdy_q        <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      pbit_q       <= pbit_d;
      dout_q       <= dout_d;
      rdy_q        <= rdy_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign rdy        = rdy_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_receiver.sv
// tb/tb_receiver.sv - directed and randomized checks of the UART receiver against a frame-level model
module tb_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_clk_en = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] dout;
  logic       rdy;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rise_cyc = -1;
  int   fs = 0;
  int   off = 0;
  logic rdy_prev = 1'b0;
  bit   pending = 1'b0;
  bit   saw_busy;

  receiver #(.OVERSAMPLE(16), .PARITY_ODD(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_clk_en  (rx_clk_en),
    .rdy_clr    (rdy_clr),
    .dout       (dout),
    .rdy        (rdy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdy && !rdy_prev) rise_cyc = cyc;
    rdy_prev = rdy;
  end

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Drives the first nbits bits of a frame, 16 clk per bit; called at a negedge.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int nbits);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      rx = f[b];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] d, input logic p, input logic s,
                             input bit clr_same);
    chk({tag, ".rdy"}, rdy, 8'd1);
    chk({tag, ".dout"}, dout, d);
    chk({tag, ".parity_err"}, parity_err, {7'd0, (^d) ^ p});
    chk({tag, ".frame_err"}, frame_err, {7'd0, ~s});
    chk({tag, ".overrun"}, overrun, {7'd0, pending & ~clr_same});
    pending = 1'b1;
  endtask

  task automatic clear();
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
    pending = 1'b0;
  endtask

  task automatic wait_rdy(input string tag);
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".wait_rdy"}, {7'd0, rdy}, 8'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".dout"}, dout, 8'h00);
    chk({tag, ".rdy"}, rdy, 8'd0);
    chk({tag, ".parity_err"}, parity_err, 8'd0);
    chk({tag, ".frame_err"}, frame_err, 8'd0);
    chk({tag, ".overrun"}, overrun, 8'd0);
    chk({tag, ".rx_busy"}, rx_busy, 8'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    int         n;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Clean frame
    fs = cyc;
    send_frame(8'hA5, 1'b0, 1'b1, 11);
    check_frame("clean", 8'hA5, 1'b0, 1'b1, 1'b0);
    chk("clean.rx_busy", rx_busy, 8'd0);
    clear();
    chk("clean.cleared", rdy, 8'd0);

    // Parity error then clear
    send_frame(8'h01, 1'b0, 1'b1, 11);
    check_frame("parity", 8'h01, 1'b0, 1'b1, 1'b0);
    clear();
    chk("parity.clr.rdy", rdy, 8'd0);
    chk("parity.clr.perr", parity_err, 8'd0);
    chk("parity.clr.dout", dout, 8'h01);

    // Framing error followed by a held-low break
    send_frame(8'h3C, 1'b0, 1'b0, 11);
    check_frame("frame", 8'h3C, 1'b0, 1'b0, 1'b0);
    clear();
    for (int k = 0; k < 3; k++) begin
      wait_rdy("break");
      check_frame("break", 8'h00, 1'b0, 1'b0, 1'b0);
      clear();
    end
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("break.recover.rdy", rdy, 8'd0);
    chk("break.recover.busy", rx_busy, 8'd0);

    // Start-bit glitch
    saw_busy = 1'b0;
    rx = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_busy |= rx_busy;
    end
    rx = 1'b1;
    repeat (30) begin
      @(negedge clk);
      saw_busy |= rx_busy;
    end
    chk("glitch.busy_pulse", {7'd0, saw_busy}, 8'd1);
    chk("glitch.rdy", rdy, 8'd0);
    chk("glitch.busy_end", rx_busy, 8'd0);

    // Overrun: two frames without clear
    fs = cyc;
    send_frame(8'h11, 1'b0, 1'b1, 11);
    off = rise_cyc - fs;
    check_frame("ovr.first", 8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 11);
    check_frame("ovr.second", 8'h22, 1'b0, 1'b1, 1'b0);
    clear();

    // Clear coinciding with the completion edge of the second frame
    send_frame(8'h11, 1'b0, 1'b1, 11);
    check_frame("coinc.first", 8'h11, 1'b0, 1'b1, 1'b0);
    fs = cyc;
    fork
      send_frame(8'h22, 1'b0, 1'b1, 11);
      begin
        n = 0;
        while (cyc != fs + off - 1 && n < 400) begin
          @(negedge clk);
          n++;
        end
        rdy_clr = 1'b1;
        @(negedge clk);
        rdy_clr = 1'b0;
      end
    join
    check_frame("coinc.second", 8'h22, 1'b0, 1'b1, 1'b1);

    // Reset during data bit 4 of 0xFF, with a byte still pending
    send_frame(8'hFF, 1'b0, 1'b1, 5);
    repeat (8) @(negedge clk);
    chk("rst.pre_busy", rx_busy, 8'd1);
    rst = 1'b1;
    #1;
    check_all_zero("rst.mid");
    pending = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("rst.after.rdy", rdy, 8'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 11);
    check_frame("rst.next", 8'h5A, 1'b0, 1'b1, 1'b0);
    clear();

    // Loopback sweep with random parity corruption and random idle gaps
    for (int i = 0; i < 256; i++) begin
      d = i[7:0];
      p = (^d) ^ ($urandom_range(0, 7) == 0);
      send_frame(d, p, 1'b1, 11);
      check_frame("loop", d, p, 1'b1, 1'b0);
      clear();
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
